// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty ramp controller and its period counter.
// Holds the FSM state encoding, the counter width, the full-scale duty value
// and the saturating duty-step helper used by the ramp datapath.
package pwm_ctrl_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_MAX = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ctrl_state_e;

  // Move cur toward tgt by min(step, |tgt-cur|). Done in 9 bits so the
  // difference and the sum can never wrap; the result never passes tgt.
  function automatic logic [PWM_CNT_W-1:0] ramp_step(
    input logic [PWM_CNT_W-1:0] cur,
    input logic [PWM_CNT_W-1:0] tgt,
    input logic [PWM_CNT_W-1:0] step
  );
    logic [PWM_CNT_W:0] cur9;
    logic [PWM_CNT_W:0] tgt9;
    logic [PWM_CNT_W:0] stp9;
    logic [PWM_CNT_W:0] gap9;
    logic [PWM_CNT_W:0] mv9;
    logic [PWM_CNT_W:0] nxt9;
    cur9 = {1'b0, cur};
    tgt9 = {1'b0, tgt};
    stp9 = {1'b0, step};
    if (tgt9 >= cur9) begin
      gap9 = tgt9 - cur9;
      mv9  = (gap9 < stp9) ? gap9 : stp9;
      nxt9 = cur9 + mv9;
    end else begin
      gap9 = cur9 - tgt9;
      mv9  = (gap9 < stp9) ? gap9 : stp9;
      nxt9 = cur9 - mv9;
    end
    return PWM_CNT_W'(nxt9);
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter: counts 0..255 and wraps while enabled,
// holds while disabled. boundary_o marks the last count of a period so that
// anything updated on it takes effect from count 0 of the next period.
module pwm_period_counter
  import pwm_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [PWM_CNT_W-1:0] count_o,
  output logic                 boundary_o
);

  logic [PWM_CNT_W-1:0] cnt_q;
  logic [PWM_CNT_W-1:0] cnt_d;

  // Next count: natural wrap from 255 to 0, hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + PWM_CNT_W'(1);
    end
  end

  // Period count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign boundary_o = en_i && (cnt_q == PWM_DUTY_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller. Accepts a target duty over a valid/ready
// handshake and walks the registered duty output toward it, changing duty
// only at PWM period boundaries so each value applies to whole periods.
// Build option: define PWM_CTRL_RAMP_EN for stepped ramping (STEP per
// DIV periods); without it the target is loaded at the first boundary.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter logic [PWM_CNT_W-1:0] STEP = 8'd1,
  parameter int unsigned          DIV  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cmd_valid,
  input  logic [PWM_CNT_W-1:0] cmd_duty,
  output logic                 cmd_ready,
  output logic [PWM_CNT_W-1:0] duty,
  output logic                 period_start,
  output logic                 busy,
  output logic                 done
);

  // Without ramping, a full-scale step with no division reaches any target
  // in one boundary update, so both builds share one datapath.
`ifdef PWM_CTRL_RAMP_EN
  localparam logic [PWM_CNT_W-1:0] STEP_EFF = STEP;
  localparam logic [PWM_CNT_W-1:0] DIV_LAST = PWM_CNT_W'(DIV - 1);
`else
  localparam logic [PWM_CNT_W-1:0] STEP_EFF = STEP | PWM_DUTY_MAX;
  localparam logic [PWM_CNT_W-1:0] DIV_LAST = PWM_CNT_W'(DIV - 1) & '0;
`endif

  logic [PWM_CNT_W-1:0] count;
  logic                 boundary;

  ctrl_state_e          state_q;
  logic [PWM_CNT_W-1:0] duty_q;
  logic [PWM_CNT_W-1:0] target_q;
  logic [PWM_CNT_W-1:0] div_q;
  logic                 cmd_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [PWM_CNT_W-1:0] step_duty_d;

  pwm_period_counter u_period_counter (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .en_i       (enable),
    .count_o    (count),
    .boundary_o (boundary)
  );

  // Candidate duty for the next ramp step toward the latched target.
  always_comb begin
    step_duty_d = ramp_step(duty_q, target_q, STEP_EFF);
  end

  // Control FSM with registered handshake/status outputs. Ramp progress is
  // tied to boundary, which already includes enable, so enable=0 freezes
  // the ramp and divider; command intake in IDLE does not depend on enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      div_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            target_q <= cmd_duty;
            if (cmd_duty == duty_q) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= ST_RAMP;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              div_q       <= '0;
            end
          end
        end
        ST_RAMP: begin
          cmd_ready_q <= 1'b0;
          if (boundary) begin
            if (div_q == DIV_LAST) begin
              div_q  <= '0;
              duty_q <= step_duty_d;
              if (step_duty_d == target_q) begin
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                cmd_ready_q <= 1'b1;
              end
            end else begin
              div_q <= div_q + PWM_CNT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign duty         = duty_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign period_start = (count == '0);

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 8'd1: duty increment or decrement per ramp step, range 1..255.
REQ-002 SHALL have parameter DIV, default 1: number of PWM periods per ramp step, range 1..256.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: run/freeze of the period counter and the ramp.
REQ-006 SHALL have port cmd_valid, input, 1 bit: target-duty command present.
REQ-007 SHALL have port cmd_duty, input, 8 bits: target duty, where 0 is 0% and 255 is 100%.
REQ-008 SHALL have port cmd_ready, output, 1 bit: controller can accept a command.
REQ-009 SHALL have port duty, output, 8 bits: registered duty value driving pwm_generator_8bit duty.
REQ-010 SHALL have port period_start, output, 1 bit: high while the internal period count equals 0.
REQ-011 SHALL have port busy, output, 1 bit: ramp in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when duty reaches target.

Function
REQ-013 SHALL keep an 8-bit period counter that increments 0..255 and wraps when enable=1; it holds its value when enable=0.
REQ-014 SHALL change duty only on the cycle where counter==255 and enable=1 (the boundary), so that each new value is in effect from count 0; no mid-period glitches.
REQ-015 SHALL implement the FSM states IDLE and RAMP.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready; target is latched at acceptance.
REQ-017 SHALL, on acceptance with cmd_duty==duty, pulse done on the next cycle and remain in IDLE.
REQ-018 SHALL, on acceptance with cmd_duty!=duty, enter RAMP, clear the DIV divider, and set busy=1 from the next cycle.
REQ-019 SHALL, in RAMP, count boundaries; on every DIV-th boundary, step duty toward target by min(STEP, |target-duty|), computed with 9-bit arithmetic; never overshoot, never wrap.
REQ-020 SHALL, on the boundary update that makes duty==target, return to IDLE with busy=0 on the next cycle and done=1 for exactly that one cycle; cmd_ready=1 in the same cycle, and a command accepted then is legal.
REQ-021 SHALL ignore cmd_valid while in RAMP; a command arriving mid-ramp is neither accepted nor queued.
REQ-022 SHALL, when enable=0, freeze the FSM, divider, duty, busy and counter; period_start follows the frozen counter.
REQ-023 SHALL assert done only as a single-cycle pulse, never held.

Reset
REQ-024 SHALL, while reset_n=0: duty=0, counter=0, divider=0, state=IDLE, cmd_ready=0, busy=0, done=0, period_start=1.
REQ-025 SHALL drive cmd_ready=1 from the first clock edge after reset_n deasserts.
REQ-026 SHALL, on reset mid-ramp, abort the ramp immediately with duty=0 and no done pulse.

Configuration
REQ-027 SHALL support macro PWM_CTRL_RAMP_EN: when defined, ramp behaviour is as in REQ-018..REQ-021.
REQ-028 SHALL, when PWM_CTRL_RAMP_EN is undefined, ignore STEP and DIV and load duty=target at the first boundary after acceptance; busy is held until that boundary and done pulses on the next cycle.

Structure
REQ-029 SHALL place the FSM state enum, PWM_CNT_W=8 and the max-duty constant 8'd255 in package pwm_ctrl_pkg.
REQ-030 SHALL instantiate one sub-module, pwm_period_counter (8-bit wrap counter with enable, outputting count and boundary), shared with pwm_generator_8bit at system level.

Verification
REQ-031 SHALL cover: STEP=16, DIV=1, macro on, duty=0, cmd 64 -> duty 16/32/48/64 at 4 consecutive boundaries; done 1 cycle after the 4th; busy low after.
REQ-032 SHALL cover: STEP=16, cmd 70 from 0 -> sequence 16,32,48,64,70; no value >70.
REQ-033 SHALL cover: STEP=64, DIV=2, duty=255, cmd 0 -> 191,127,63,0 at every 2nd boundary (8 periods total); no underflow.
REQ-034 SHALL cover: cmd 128 mid-ramp toward 64 -> cmd_ready=0, command dropped, ramp still ends at 64.
REQ-035 SHALL cover: reset_n low mid-ramp at duty=32 -> duty=0, busy=0, no done; next command accepted normally.
REQ-036 SHALL cover: macro off, cmd 192 from 0 -> duty jumps to 192 at the first boundary, done the next cycle; enable=0 for 100 cycles mid-period delays the boundary by exactly 100 cycles.
